// File: rtl/key_sched_pkg.sv
// Shared constants for the key event scheduler: event kinds, queue entry width
// and the repeat timer width.
package key_sched_pkg;

  localparam int ENTRY_W = 5;
  localparam int TIMER_W = 24;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_REPEAT  = 2'b10
  } ev_type_e;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// An empty FIFO presents an all-zero head entry.
module event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Turns key level changes into press/release/repeat events, arbitrates them
// round-robin into an event queue and tracks lost edges in a sticky flag.
module key_event_scheduler
  import key_sched_pkg::*;
#(
  parameter int                 NUM_KEYS      = 8,
  parameter logic [TIMER_W-1:0] REPEAT_DELAY  = 24'd5_000_000,
  parameter logic [TIMER_W-1:0] REPEAT_PERIOD = 24'd1_000_000,
  parameter int                 FIFO_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_level,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [2:0]          ev_code,
  output logic [1:0]          ev_type,
  output logic                overflow,
  input  logic                clear_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_KEYS-1:0] prev, press_pend, rel_pend, rep_pend;
  logic [NUM_KEYS-1:0] press_nxt, rel_nxt, rep_nxt;
  logic [NUM_KEYS-1:0] press_edge, rel_edge, cand_valid;
  ev_type_e            cand_type [NUM_KEYS];

  logic               rep_active;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         rep_key;
  logic [2:0]         last_grant;
  logic               rep_fire, rep_release, any_press, lost;
  logic [2:0]         press_key;

  logic               found, grant;
  logic [2:0]         grant_key, idx;
  logic [3:0]         idx_w;
  ev_type_e           grant_type;

  logic [ENTRY_W-1:0] head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               unused_full;

  assign press_edge  = key_level & ~prev;
  assign rel_edge    = ~key_level & prev;
  assign rep_fire    = rep_active && (timer == '0);
  assign rep_release = rel_edge[rep_key];

  // A press outranks a release so a quick tap reports in order; a pending
  // release also masks any repeat of the same key.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      cand_valid[k] = press_pend[k] | rel_pend[k] | rep_pend[k];
      cand_type[k]  = EV_REPEAT;
      if (press_pend[k])    cand_type[k] = EV_PRESS;
      else if (rel_pend[k]) cand_type[k] = EV_RELEASE;
    end
  end

  // Round-robin search starting one past the last granted key.
  always_comb begin
    found      = 1'b0;
    grant_key  = '0;
    grant_type = EV_PRESS;
    idx_w      = '0;
    idx        = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      idx_w = {1'b0, last_grant} + 4'(i) + 4'd1;
      if (idx_w >= 4'(NUM_KEYS)) idx_w = idx_w - 4'(NUM_KEYS);
      idx = idx_w[2:0];
      if (!found && cand_valid[idx]) begin
        found      = 1'b1;
        grant_key  = idx;
        grant_type = cand_type[idx];
      end
    end
  end

  assign grant = found && (fifo_count < CW'(FIFO_DEPTH));

  // Grant clears are applied first so an edge arriving as its pend bit is
  // consumed is kept rather than counted as lost.
  always_comb begin
    press_nxt = press_pend;
    rel_nxt   = rel_pend;
    rep_nxt   = rep_pend;
    lost      = 1'b0;
    any_press = 1'b0;
    press_key = '0;
    if (grant) begin
      case (grant_type)
        EV_PRESS:   press_nxt[grant_key] = 1'b0;
        EV_RELEASE: rel_nxt[grant_key]   = 1'b0;
        default:    rep_nxt[grant_key]   = 1'b0;
      endcase
    end
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (press_edge[k]) begin
        any_press = 1'b1;
        press_key = 3'(k);
        if (press_nxt[k]) lost = 1'b1;
        else              press_nxt[k] = 1'b1;
      end
      if (rel_edge[k]) begin
        if (rel_nxt[k]) lost = 1'b1;
        else            rel_nxt[k] = 1'b1;
      end
    end
    if (rep_release)   rep_nxt[rep_key] = 1'b0;
    else if (rep_fire) rep_nxt[rep_key] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev       <= '0;
      press_pend <= '0;
      rel_pend   <= '0;
      rep_pend   <= '0;
      rep_active <= 1'b0;
      timer      <= '0;
      rep_key    <= '0;
      last_grant <= 3'(NUM_KEYS - 1);
      overflow   <= 1'b0;
    end else begin
      prev       <= key_level;
      press_pend <= press_nxt;
      rel_pend   <= rel_nxt;
      rep_pend   <= rep_nxt;
      if (grant) last_grant <= grant_key;
      if (lost)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
      // Highest-index press restarts the timer; a release of the tracked key
      // stops it unless a new press arrives in the same cycle.
      if (any_press) begin
        rep_key    <= press_key;
        timer      <= REPEAT_DELAY - 24'd1;
        rep_active <= 1'b1;
      end else if (rep_release) begin
        rep_active <= 1'b0;
      end else if (rep_active) begin
        timer <= (timer == '0) ? REPEAT_PERIOD - 24'd1 : timer - 1'b1;
      end
    end
  end

  // Handshake: an event transfers on a rising edge where ev_valid and
  // ev_ready are both 1; the presented entry only changes after a transfer.
  event_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .wdata ({grant_type, grant_key}),
    .pop   (ev_valid && ev_ready),
    .rdata (head),
    .count (fifo_count),
    .full  (unused_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = head[2:0];
  assign ev_type  = head[4:3];

endmodule

// File: doc/key_event_scheduler.md
KEY_EVENT_SCHEDULER -- requirements
Module: key_event_scheduler

Interface
REQ-001 Parameter NUM_KEYS, default 8: number of key inputs; legal values are 2 to 8.
REQ-002 Parameter REPEAT_DELAY, default 24'd5_000_000: cycles from press to first repeat event; legal values are 1 and above.
REQ-003 Parameter REPEAT_PERIOD, default 24'd1_000_000: cycles between subsequent repeat events; legal values are 1 and above.
REQ-004 Parameter FIFO_DEPTH, default 4: event queue depth; the value SHALL be a power of 2.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port key_level, input, NUM_KEYS bits: debounced, synchronized key levels; 1 means held.
REQ-008 Port ev_valid, output, 1 bit: an event is presented.
REQ-009 Port ev_ready, input, 1 bit: the consumer accepts the presented event.
REQ-010 Port ev_code, output, 3 bits: key index of the presented event.
REQ-011 Port ev_type, output, 2 bits: event kind; 00 = press, 01 = release, 10 = repeat, 11 is never emitted.
REQ-012 Port overflow, output, 1 bit: sticky flag; set when a press or release edge is lost.
REQ-013 Port clear_overflow, input, 1 bit: synchronous clear of the overflow flag.

Function
REQ-014 The block SHALL hold a per-key previous-level register, prev, which is 0 after reset; a key held through reset SHALL therefore produce a press event.
REQ-015 Edge detection: on a clock edge where key_level[k]=1 and prev[k]=0, press_pend[k] SHALL be set; on one where key_level[k]=0 and prev[k]=1, rel_pend[k] SHALL be set; prev SHALL be updated to key_level on every edge.
REQ-016 Lost edges: an edge for a key whose pend bit of the same type is already set SHALL be dropped and SHALL set overflow.
REQ-017 overflow SHALL be set and cleared as follows.
- A set and a clear_overflow in the same cycle SHALL leave overflow at 1.
- Otherwise clear_overflow=1 SHALL clear overflow to 0.
REQ-018 Per-key candidate event, in priority order: press_pend, then rel_pend, then rep_pend.
- A press is emitted before a release, so a quick tap yields press then release.
- A repeat is never emitted while rel_pend of that key is set.
REQ-019 Arbitration is round-robin over keys.
- The search starts at the index after the last granted key.
- After reset the search starts at key 0.
- At most one grant per cycle.
- A grant occurs only when the FIFO count is below FIFO_DEPTH; there is no bypass of a full FIFO by a same-cycle pop.
REQ-020 On a grant, the entry {type, code} SHALL be written to the FIFO on that edge, and the granted pend bit SHALL be cleared on that same edge.
REQ-021 Latency: a key_level change sampled at edge E1 sets its pend bit at E1; with the FIFO empty and no competing pend bits, ev_valid SHALL be 1 after edge E2.
REQ-022 Output handshake:
- ev_valid = FIFO not empty.
- ev_code and ev_type SHALL be taken from the head entry.
- The FIFO SHALL pop on an edge where ev_valid=1 and ev_ready=1.
- While ev_valid=1 and ev_ready=0, ev_code and ev_type SHALL be held stable.
REQ-023 Repeat engine: one shared 24-bit timer, a register rep_key and a flag rep_active.
- A press edge on key k SHALL load rep_key=k, timer=REPEAT_DELAY-1 and rep_active=1.
- If several press edges occur in the same cycle, the highest index SHALL win.
REQ-024 While rep_active=1 and timer≠0, the timer SHALL decrement by 1 per cycle.
REQ-025 When rep_active=1 and timer=0:
- rep_pend[rep_key] SHALL be set; if it is already set the repeat is coalesced and SHALL NOT set overflow.
- The timer SHALL be reloaded with REPEAT_PERIOD-1.
REQ-026 A release edge of rep_key SHALL clear rep_active and clear rep_pend[rep_key].
- This SHALL take priority over a timer expiry in the same cycle.
- A new press edge in the same cycle SHALL take priority over the release.
REQ-027 A release of any key other than rep_key SHALL NOT affect the repeat engine.

Reset
REQ-028 When rst_n=0 at a clock edge, the block SHALL be reset as follows.
- prev, all pend bits, rep_active, timer and rep_key SHALL be cleared to 0.
- The FIFO pointers and count SHALL be cleared to 0.
- The round-robin pointer SHALL be set so the next search starts at key 0.
- overflow SHALL be cleared to 0.
REQ-029 Output values during and immediately after reset: ev_valid=0, ev_code=0, ev_type=00 and overflow=0. Assertion of rst_n mid-operation SHALL discard all queued and pending events.

Structure
REQ-030 A shared package key_sched_pkg SHALL hold:
- the event type constants EV_PRESS, EV_RELEASE and EV_REPEAT;
- the event entry width (5 bits);
- the timer width (24 bits).
REQ-031 The queue SHALL be a sub-module named event_fifo: a synchronous FIFO parameterized by width and depth, with count, full and empty outputs. The edge detection, arbiter and repeat engine SHALL remain in the top module.

Verification
REQ-032 The bench SHALL use REPEAT_DELAY=10, REPEAT_PERIOD=4 and FIFO_DEPTH=4, and SHALL cover the following directed scenarios.
- Scenario 1: ev_ready=1; key_level[3] rises at E1 -> ev_valid=1 after E2 with code=3 and type=00, valid for exactly one cycle.
- Scenario 2: hold key 2 for 30 cycles, ev_ready=1 -> one press, repeats at press+10, +14, +18, +22, +26, then one release, and no further repeat after the release.
- Scenario 3: keys 1, 4 and 6 rise together, ev_ready=1 -> presses in order 1, 4, 6 on consecutive cycles, and repeats follow key 6 only.
- Scenario 4: ev_ready=0; six single-cycle taps on keys 0-5 -> FIFO holds 4 entries; the remaining pend bits are held, not lost, and overflow=0; raising ev_ready then drains all events in round-robin order.
- Scenario 5: ev_ready=0; key 0 tapped three times while the FIFO is full -> overflow=1; clear_overflow pulse -> overflow=0.
- Scenario 6: rst_n=0 for one edge with the FIFO holding 3 entries and key 5 held -> ev_valid=0 after that edge; after release of reset, a press for key 5 is emitted and no stale event appears.
